// File: rtl/count_disp_pkg.sv
// Shared types and segment decode for the counter display stage.
// Segment encoding: {g,f,e,d,c,b,a}, active low (common anode).
package count_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_F     = 7'h0E;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/count_bcd_display_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits.
// One capture cycle, eight shift cycles, one load cycle.
module bin2bcd_seq
  import count_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] value,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  conv_state_t state_q, state_d;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic [2:0]  cnt_q;
  logic [7:0]  cap_q;
  logic [3:0]  hund_q, tens_q, ones_q;

  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5)
      bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5)
      bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    if (bcd_q[11:8] >= 4'd5)
      bcd_adj[11:8] = bcd_q[11:8] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            bin_q <= din;
            cap_q <= din;
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
          cnt_q <= cnt_q + 3'd1;
        end
        DONE: begin
          hund_q <= bcd_q[11:8];
          tens_q <= bcd_q[7:4];
          ones_q <= bcd_q[3:0];
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign value = cap_q;
  assign hund  = hund_q;
  assign tens  = tens_q;
  assign ones  = ones_q;

endmodule

// File: rtl/count_bcd_display.sv
// 4-digit multiplexed display of the counter value plus status digit.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int FLAG_HOLD = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] count,
  input  logic       flag,
  input  logic       zero,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(FLAG_HOLD + 1);

  logic [7:0]    last_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [HW-1:0] hold_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q;

  logic          start;
  logic          conv_done;
  logic [7:0]    conv_val;
  logic [3:0]    hund, tens, ones;

  assign start = (count != last_q);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (count),
    .busy  (busy),
    .done  (conv_done),
    .value (conv_val),
    .hund  (hund),
    .tens  (tens),
    .ones  (ones)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'b1111;
    unique case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_decode(ones);
      end
      2'd1: begin
        an_d  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
        if (hund == 4'd0 && tens == 4'd0)
          seg_d = SEG_BLANK;
        else
          seg_d = seg_decode(tens);
`else
        seg_d = seg_decode(tens);
`endif
      end
      2'd2: begin
        an_d  = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
        if (hund == 4'd0)
          seg_d = SEG_BLANK;
        else
          seg_d = seg_decode(hund);
`else
        seg_d = seg_decode(hund);
`endif
      end
      2'd3: begin
        an_d = 4'b0111;
        // Held flag outranks the zero indicator.
        if (hold_q != '0)
          seg_d = SEG_F;
        else if (zero)
          seg_d = SEG_DASH;
        else
          seg_d = SEG_BLANK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      if (conv_done)
        last_q <= conv_val;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      if (flag)
        hold_q <= HW'(FLAG_HOLD);
      else if (hold_q != '0)
        hold_q <= hold_q - HW'(1);
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= 1'b1;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display (SCAN_DIV=4, FLAG_HOLD=8).
// Expected codes are hand-computed; LEADING_ZERO_BLANK_EN selects blanks.
module tb_count_bcd_display;

  localparam int SCAN_DIV  = 4;
  localparam int FLAG_HOLD = 8;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] count = 8'd0;
  logic       flag = 1'b0;
  logic       zero = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int total = 0;
  int passed = 0;

  count_bcd_display #(
    .SCAN_DIV  (SCAN_DIV),
    .FLAG_HOLD (FLAG_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .count (count),
    .flag  (flag),
    .zero  (zero),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       zro;
    logic [6:0] o;
    logic [6:0] t;
    logic [6:0] h;
    logic [6:0] s;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a fresh activation of the given anode pattern.
  task automatic wait_an(input logic [3:0] target, input string name);
    int k = 0;
    while (an == target && k < 64) begin
      @(negedge clk);
      k++;
    end
    while (an != target && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (an != target) begin
      total++;
      $display("FAIL %s: timeout an=%b expected %b", name, an, target);
    end
  endtask

  task automatic check_digits(input string name,
                              input logic [6:0] o,
                              input logic [6:0] t,
                              input logic [6:0] h,
                              input logic [6:0] s);
    wait_an(4'b1110, name);
    check({name, "_ones"}, seg, o);
    wait_an(4'b1101, name);
    check({name, "_tens"}, seg, t);
    wait_an(4'b1011, name);
    check({name, "_hund"}, seg, h);
    wait_an(4'b0111, name);
    check({name, "_stat"}, seg, s);
  endtask

  initial begin
    logic [3:0] an_seq[4];
    logic [6:0] seg_seq[4];
    int nb;
    logic exp_b;

    vecs[0] = '{8'd255, 1'b0, 7'h12, 7'h12, 7'h24, 7'h7F};
    vecs[1] = '{8'd7,   1'b1, 7'h78, LZ,    LZ,    7'h3F};
    vecs[2] = '{8'd105, 1'b0, 7'h12, 7'h40, 7'h79, 7'h7F};
    vecs[3] = '{8'd99,  1'b0, 7'h10, 7'h10, LZ,    7'h7F};
    vecs[4] = '{8'd200, 1'b1, 7'h40, 7'h40, 7'h24, 7'h3F};
    vecs[5] = '{8'd143, 1'b0, 7'h30, 7'h19, 7'h79, 7'h7F};
    vecs[6] = '{8'd0,   1'b1, 7'h40, LZ,    LZ,    7'h3F};
    vecs[7] = '{8'd10,  1'b0, 7'h40, 7'h79, LZ,    7'h7F};

    an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_seq = '{7'h40, LZ, LZ, 7'h7F};

    // Reset values
    @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_busy", busy, 1'b0);

    // Scan order with count=0
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      if (d != 0) tick(SCAN_DIV);
      check($sformatf("scan_an%0d", d), an, an_seq[d]);
      check($sformatf("scan_seg%0d", d), seg, seg_seq[d]);
      check($sformatf("scan_busy%0d", d), busy, 1'b0);
    end

    // 0 -> 60: nine busy cycles then display
    count = 8'd60;
    @(negedge clk);
    check("conv60_busy_first", busy, 1'b1);
    nb = 1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("conv60_busy_len", nb, 9);
    check_digits("d60", 7'h40, 7'h02, LZ, 7'h7F);

    // Table of conversions and zero indicator
    for (int v = 0; v < 8; v++) begin
      count = vecs[v].cnt;
      zero  = vecs[v].zro;
      tick(12);
      check_digits($sformatf("vec%0d", v),
                   vecs[v].o, vecs[v].t, vecs[v].h, vecs[v].s);
    end
    zero = 1'b0;

    // Change during conversion: 10 -> 60, then 61 mid-shift
    count = 8'd60;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_b = (i <= 9) || (i >= 11 && i <= 19);
      check($sformatf("midchg_busy%0d", i), busy, exp_b);
      if (i == 3) count = 8'd61;
    end
    check_digits("d61", 7'h79, 7'h02, LZ, 7'h7F);

    // Flag hold expires exactly at a status-window boundary
    wait_an(4'b0111, "flag_align");
    tick(7);
    flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    wait_an(4'b0111, "flag_win");
    check("flag_last_f", seg, 7'h0E);
    @(negedge clk);
    check("flag_expired_an", an, 4'b0111);
    check("flag_expired_seg", seg, 7'h7F);

    // Single pulse seen early in a window, then gone
    wait_an(4'b1011, "pulse_align");
    flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    wait_an(4'b0111, "pulse_on");
    check("pulse_f", seg, 7'h0E);
    wait_an(4'b0111, "pulse_off");
    check("pulse_blank", seg, 7'h7F);

    // zero alone, then flag with zero
    zero = 1'b1;
    wait_an(4'b0111, "zero_only");
    check("zero_dash", seg, 7'h3F);
    flag = 1'b1;
    wait_an(4'b0111, "flag_zero");
    check("flag_over_zero", seg, 7'h0E);
    flag = 1'b0;
    zero = 1'b0;
    tick(12);

    // Reset in the middle of a conversion
    count = 8'd200;
    tick(2);
    check("rst_mid_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_an", an, 4'b1111);
    check("rst_mid_seg", seg, 7'h7F);
    check("rst_mid_dp", dp, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", seg, 7'h40);
    check("post_rst_busy", busy, 1'b1);
    tick(12);
    check_digits("post_rst", 7'h40, 7'h40, 7'h24, 7'h7F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
